// File: rtl/cv32e40s_data_obi_responder.sv
// OBI data-side memory responder: grants, services and queues responses for up to
// DEPTH outstanding transactions, with bench-controlled grant/response stalls.
module cv32e40s_data_obi_responder #(
  parameter int DEPTH          = 4,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     data_req_i,
  output logic                     data_gnt_o,
  input  logic [31:0]              data_addr_i,
  input  logic                     data_we_i,
  input  logic [3:0]               data_be_i,
  input  logic [31:0]              data_wdata_i,
  output logic                     data_rvalid_o,
  output logic [31:0]              data_rdata_o,
  output logic                     data_err_o,
  input  logic                     gnt_stall_i,
  input  logic                     rvalid_stall_i,
  output logic [$clog2(DEPTH):0]   outstanding_o
);

  localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_WIDTH = $clog2(DEPTH) + 1;
  localparam int MEM_WORDS = 2 ** MEM_ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(DEPTH);

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } entry_t;

  entry_t                    fifo_q [DEPTH];
  logic [31:0]               mem_q  [MEM_WORDS];
  logic [PTR_WIDTH-1:0]      wptr_q;
  logic [PTR_WIDTH-1:0]      rptr_q;
  logic [CNT_WIDTH-1:0]      count_q;
  logic                      accept;
  logic                      pop;
  logic                      in_range;
  logic [MEM_ADDR_WIDTH-1:0] word_idx;
  entry_t                    push_entry;
  logic                      unused_addr_lsb;

  assign unused_addr_lsb = ^data_addr_i[1:0];
  assign word_idx        = data_addr_i[MEM_ADDR_WIDTH+1:2];
  assign in_range        = (data_addr_i[31:2] >> MEM_ADDR_WIDTH) == '0;

  // Grant looks only at the registered count, so a full queue stays closed
  // for the cycle in which it drains an entry.
  assign data_gnt_o    = !gnt_stall_i && (count_q < DEPTH_CNT);
  assign accept        = data_req_i && data_gnt_o;
  assign data_rvalid_o = (count_q != '0) && !rvalid_stall_i;
  assign pop           = data_rvalid_o;

  always_comb begin
    push_entry = '0;
    if (!in_range) begin
      push_entry.err = 1'b1;
    end else if (!data_we_i) begin
      push_entry.rdata = mem_q[word_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (accept && in_range && data_we_i) begin
      for (int unsigned n = 0; n < 4; n++) begin
        if (data_be_i[n]) begin
          mem_q[word_idx][8*n +: 8] <= data_wdata_i[8*n +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      fifo_q[wptr_q] <= push_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (accept) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      case ({accept, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  assign data_rdata_o  = data_rvalid_o ? fifo_q[rptr_q].rdata : '0;
  assign data_err_o    = data_rvalid_o ? fifo_q[rptr_q].err   : 1'b0;
  assign outstanding_o = count_q;

endmodule
